sync_level2pulse_mc: RTL and testbench

Multi-channel successor to the single-bit level-to-pulse synchroniser. It has NUM_CH independent channels. Each channel runs: a FLOP_NUM-deep synchroniser, a programmable stability (glitch) filter, per-channel edge selection (rise/fall/both/off), and a sticky event status bit with clear. It sits at the boundary of the clk domain and conditions asynchronous level inputs (interrupt lines, handshake levels, pad strobes) into single-cycle event pulses for core/SoC logic.

---
 rtl/sync_level2pulse_mc.sv | 115 +++++++++++
 tb/tb_sync_level2pulse_mc.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_level2pulse_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sync_level2pulse_mc                                               |
// | Desc   : Multi-channel level synchroniser with stability filter, per-channel |
// |          edge selection, one-cycle event pulses and sticky event status.     |
// |          Optional per-channel saturating event counters are built when the   |
// |          macro SYNC_L2P_MC_EVT_CNT_EN is defined; otherwise evt_cnt reads 0. |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module sync_level2pulse_mc #(
    parameter int NUM_CH     = 4,
    parameter int FLOP_NUM   = 3,
    parameter int FILTER_CYC = 1,
    parameter int EVT_CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic [NUM_CH-1:0]           sync_in,
    input  logic [2*NUM_CH-1:0]         edge_mode,
    input  logic [NUM_CH-1:0]           evt_clr,
    output logic [NUM_CH-1:0]           level_out,
    output logic [NUM_CH-1:0]           pulse_out,
    output logic [NUM_CH-1:0]           evt_sts,
    output logic                        evt_any,
    output logic [NUM_CH*EVT_CNT_W-1:0] evt_cnt
);

    localparam int                 c_cnt_w    = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_flt_last = c_cnt_w'(FILTER_CYC - 1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [FLOP_NUM-1:0] r_sync;
            logic [c_cnt_w-1:0]  r_flt_cnt;
            logic                r_flt_lvl;
            logic                r_flt_d;
            logic                r_sts;
            logic                w_sync_lvl;
            logic [1:0]          w_mode;
            logic                w_rise;
            logic                w_fall;
            logic                w_pulse;

            assign w_sync_lvl = r_sync[FLOP_NUM-1];
            assign w_mode     = edge_mode[2*gi +: 2];

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[FLOP_NUM-2:0], sync_in[gi]};
                end
            end

            // A new level is accepted only after it has held for FILTER_CYC cycles.
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    r_flt_lvl <= 1'b0;
                    r_flt_cnt <= '0;
                end else if (w_sync_lvl == r_flt_lvl) begin
                    r_flt_cnt <= '0;
                end else if (r_flt_cnt == c_flt_last) begin
                    r_flt_lvl <= w_sync_lvl;
                    r_flt_cnt <= '0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + c_cnt_w'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    r_flt_d <= 1'b0;
                    r_sts   <= 1'b0;
                end else begin
                    r_flt_d <= r_flt_lvl;
                    r_sts   <= (r_sts & ~evt_clr[gi]) | w_pulse;
                end
            end

            // Mode gating is combinational so a mode change applies in the same cycle.
            assign w_rise  = r_flt_lvl & ~r_flt_d;
            assign w_fall  = ~r_flt_lvl & r_flt_d;
            assign w_pulse = (w_rise & w_mode[0]) | (w_fall & w_mode[1]);

            assign level_out[gi] = r_flt_lvl;
            assign pulse_out[gi] = w_pulse;
            assign evt_sts[gi]   = r_sts;

`ifdef SYNC_L2P_MC_EVT_CNT_EN
            logic [EVT_CNT_W-1:0] r_evt_cnt;

            // Clear restarts the count, so a pulse coinciding with clear leaves 1.
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    r_evt_cnt <= '0;
                end else if (evt_clr[gi]) begin
                    r_evt_cnt <= EVT_CNT_W'(w_pulse);
                end else if (w_pulse && (r_evt_cnt != {EVT_CNT_W{1'b1}})) begin
                    r_evt_cnt <= r_evt_cnt + EVT_CNT_W'(1);
                end
            end

            assign evt_cnt[gi*EVT_CNT_W +: EVT_CNT_W] = r_evt_cnt;
`endif
        end
    endgenerate

`ifndef SYNC_L2P_MC_EVT_CNT_EN
    assign evt_cnt = '0;
`endif

    assign evt_any = |evt_sts;

endmodule
`default_nettype wire

// File: tb/tb_sync_level2pulse_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sync_level2pulse_mc                                            |
// | Desc   : Self-checking bench for sync_level2pulse_mc with FILTER_CYC=1 and  |
// |          FILTER_CYC=4 instances sharing stimulus.                          |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sync_level2pulse_mc;

    localparam int NCH = 4;
    localparam int FN  = 3;
    localparam int CW  = 2;

    logic       clk       = 1'b0;
    logic       rst_b     = 1'b0;
    logic [3:0] sync_in   = '0;
    logic [7:0] edge_mode = '0;
    logic [3:0] evt_clr   = '0;

    logic [3:0] lvl [2];
    logic [3:0] pls [2];
    logic [3:0] sts [2];
    logic       any [2];
    logic [7:0] cnt [2];

    int checks   = 0;
    int failures = 0;

    // Reference model state: index 0 -> FILTER_CYC=1 instance, 1 -> FILTER_CYC=4.
    int          m_f [2] = '{1, 4};
    logic [63:0] m_inh [NCH];
    logic [63:0] m_sh  [2][NCH];
    logic        m_flt [2][NCH];
    logic        m_rise[2][NCH];
    logic        m_fall[2][NCH];
    logic        m_sts [2][NCH];
    int          m_cnt [2][NCH];

    always #5 clk = ~clk;

    sync_level2pulse_mc #(.NUM_CH(NCH), .FLOP_NUM(FN), .FILTER_CYC(1), .EVT_CNT_W(CW)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .sync_in(sync_in), .edge_mode(edge_mode), .evt_clr(evt_clr),
        .level_out(lvl[0]), .pulse_out(pls[0]), .evt_sts(sts[0]), .evt_any(any[0]), .evt_cnt(cnt[0])
    );

    sync_level2pulse_mc #(.NUM_CH(NCH), .FLOP_NUM(FN), .FILTER_CYC(4), .EVT_CNT_W(CW)) u_dut4 (
        .clk(clk), .rst_b(rst_b), .sync_in(sync_in), .edge_mode(edge_mode), .evt_clr(evt_clr),
        .level_out(lvl[1]), .pulse_out(pls[1]), .evt_sts(sts[1]), .evt_any(any[1]), .evt_cnt(cnt[1])
    );

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_inh[ch] = '0;
            for (int j = 0; j < 2; j++) begin
                m_sh[j][ch]   = '0;
                m_flt[j][ch]  = 1'b0;
                m_rise[j][ch] = 1'b0;
                m_fall[j][ch] = 1'b0;
                m_sts[j][ch]  = 1'b0;
                m_cnt[j][ch]  = 0;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (!rst_b) begin
            model_reset();
            return;
        end
        for (int j = 0; j < 2; j++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                logic        p;
                logic        nf;
                logic [63:0] mask;
                p = (m_rise[j][ch] & edge_mode[2*ch]) | (m_fall[j][ch] & edge_mode[2*ch+1]);
                m_sts[j][ch] = (m_sts[j][ch] & ~evt_clr[ch]) | p;
                if (evt_clr[ch])               m_cnt[j][ch] = p ? 1 : 0;
                else if (p && m_cnt[j][ch] < 3) m_cnt[j][ch] = m_cnt[j][ch] + 1;
                // Synchronised level seen at this edge is the input from FN edges ago.
                m_sh[j][ch] = {m_sh[j][ch][62:0], m_inh[ch][FN-1]};
                mask = (64'd1 << m_f[j]) - 64'd1;
                nf   = m_flt[j][ch];
                if ((m_sh[j][ch] & mask) == (nf ? 64'd0 : mask)) nf = ~nf;
                m_rise[j][ch] = nf & ~m_flt[j][ch];
                m_fall[j][ch] = ~nf & m_flt[j][ch];
                m_flt[j][ch]  = nf;
            end
        end
        for (int ch = 0; ch < NCH; ch++) m_inh[ch] = {m_inh[ch][62:0], sync_in[ch]};
    endtask

    function automatic logic [3:0] exp_lvl(int j);
        logic [3:0] r;
        for (int ch = 0; ch < NCH; ch++) r[ch] = m_flt[j][ch];
        return r;
    endfunction

    function automatic logic [3:0] exp_pls(int j);
        logic [3:0] r;
        for (int ch = 0; ch < NCH; ch++)
            r[ch] = (m_rise[j][ch] & edge_mode[2*ch]) | (m_fall[j][ch] & edge_mode[2*ch+1]);
        return r;
    endfunction

    function automatic logic [3:0] exp_sts(int j);
        logic [3:0] r;
        for (int ch = 0; ch < NCH; ch++) r[ch] = m_sts[j][ch];
        return r;
    endfunction

    function automatic logic [7:0] exp_cnt(int j);
        logic [7:0] r;
        r = '0;
`ifdef SYNC_L2P_MC_EVT_CNT_EN
        for (int ch = 0; ch < NCH; ch++) r[2*ch +: 2] = m_cnt[j][ch][1:0];
`endif
        return r;
    endfunction

    // Drive inputs on the falling edge, clock once, sample 1 time unit after the rising edge.
    task automatic step(input logic [3:0] in, input logic [7:0] mode, input logic [3:0] clr);
        @(negedge clk);
        sync_in   = in;
        edge_mode = mode;
        evt_clr   = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        for (int n = 0; n < 3; n++) step(4'b0000, 8'h00, 4'b0000);
        for (int j = 0; j < 2; j++) begin
            checks++;
            if ({lvl[j], pls[j], sts[j], any[j], cnt[j]} !== 21'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d: got %h expected 0", j,
                         {lvl[j], pls[j], sts[j], any[j], cnt[j]});
            end
        end
        rst_b = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step(4'b0000, 8'hFF, 4'b0000);
            for (int j = 0; j < 2; j++) begin
                checks++;
                if ({pls[j], sts[j]} !== 8'd0) begin
                    failures++;
                    $display("FAIL reset_release dut%0d: pulse/sts %b expected 00000000", j,
                             {pls[j], sts[j]});
                end
            end
        end
    endtask

    task automatic test_rise_basic();
        for (int n = 0; n < 6; n++) begin
            step(4'b0001, 8'b00_00_00_01, 4'b0000);
            checks++;
            if (lvl[0][0] !== (n >= 3) || pls[0][0] !== (n == 3) ||
                sts[0][0] !== (n >= 4) || any[0] !== (n >= 4)) begin
                failures++;
                $display("FAIL rise_basic edge%0d: lvl/pls/sts/any %b%b%b%b expected %b%b%b%b", n,
                         lvl[0][0], pls[0][0], sts[0][0], any[0],
                         n >= 3, n == 3, n >= 4, n >= 4);
            end
        end
    endtask

    task automatic test_filter();
        logic [7:0] mode;
        mode = 8'b00_00_11_01;
        for (int n = 0; n < 15; n++) begin
            step((n < 3) ? 4'b0011 : 4'b0001, mode, 4'b0000);
            checks++;
            if (lvl[1][1] !== 1'b0 || pls[1][1] !== 1'b0) begin
                failures++;
                $display("FAIL filter_glitch step%0d: lvl/pls %b%b expected 00", n,
                         lvl[1][1], pls[1][1]);
            end
        end
        for (int n = 0; n < 10; n++) begin
            step(4'b0011, mode, 4'b0000);
            checks++;
            if (lvl[1][1] !== (n >= 6) || pls[1][1] !== (n == 6)) begin
                failures++;
                $display("FAIL filter_rise edge%0d: lvl/pls %b%b expected %b%b", n,
                         lvl[1][1], pls[1][1], n >= 6, n == 6);
            end
        end
        for (int n = 0; n < 10; n++) begin
            step(4'b0001, mode, 4'b0000);
            checks++;
            if (lvl[1][1] !== (n < 6) || pls[1][1] !== (n == 6)) begin
                failures++;
                $display("FAIL filter_fall edge%0d: lvl/pls %b%b expected %b%b", n,
                         lvl[1][1], pls[1][1], n < 6, n == 6);
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0] mode;
        int         pc2;
        int         pc3;
        mode = 8'b00_10_11_01;
        pc2  = 0;
        pc3  = 0;
        step(4'b0001, mode, 4'b1111);
        for (int n = 0; n < 10; n++) begin
            step(4'b1101, mode, 4'b0000);
            pc2 += int'(pls[0][2]);
            pc3 += int'(pls[0][3]);
        end
        checks++;
        if (pc2 != 0 || pc3 != 0 || lvl[0][3] !== 1'b1 || lvl[0][2] !== 1'b1) begin
            failures++;
            $display("FAIL modes_rise: pulses ch2=%0d ch3=%0d lvl=%b expected 0 0 11",
                     pc2, pc3, lvl[0][3:2]);
        end
        for (int n = 0; n < 10; n++) begin
            step(4'b0001, mode, 4'b0000);
            pc2 += int'(pls[0][2]);
            pc3 += int'(pls[0][3]);
        end
        checks++;
        if (pc2 != 1 || pc3 != 0 || lvl[0][3] !== 1'b0 || sts[0][3:2] !== 2'b01) begin
            failures++;
            $display("FAIL modes_fall: pulses ch2=%0d ch3=%0d lvl3=%b sts=%b expected 1 0 0 01",
                     pc2, pc3, lvl[0][3], sts[0][3:2]);
        end
    endtask

    task automatic test_clear_collision();
        logic [7:0] mode;
        mode = 8'b00_10_11_01;
        for (int n = 0; n < 6; n++) step(4'b0000, mode, 4'b0000);
        step(4'b0000, mode, 4'b1111);
        checks++;
        if (any[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_all: evt_any %b expected 0", any[0]);
        end
        for (int n = 0; n < 4; n++) step(4'b0001, mode, 4'b0000);
        checks++;
        if (pls[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL clr_pulse_setup: pulse %b expected 1", pls[0][0]);
        end
        step(4'b0001, mode, 4'b0001);
        checks++;
        if (sts[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL clr_set_wins: evt_sts %b expected 1", sts[0][0]);
        end
        step(4'b0001, mode, 4'b0001);
        checks++;
        if (sts[0][0] !== 1'b0 || any[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_alone: sts/any %b%b expected 00", sts[0][0], any[0]);
        end
    endtask

    task automatic test_evt_cnt();
        logic [7:0] mode;
        logic [1:0] e1;
        logic [1:0] e3;
        mode = 8'b00_10_11_11;
`ifdef SYNC_L2P_MC_EVT_CNT_EN
        e1 = 2'd1;
        e3 = 2'd3;
`else
        e1 = 2'd0;
        e3 = 2'd0;
`endif
        step(4'b0001, mode, 4'b1111);
        for (int t = 0; t < 5; t++) begin
            for (int n = 0; n < 5; n++) step((t % 2 == 1) ? 4'b0001 : 4'b0000, mode, 4'b0000);
            if (t == 0) begin
                checks++;
                if (cnt[0][1:0] !== e1) begin
                    failures++;
                    $display("FAIL evt_cnt_first: got %0d expected %0d", cnt[0][1:0], e1);
                end
            end
        end
        checks++;
        if (cnt[0][1:0] !== e3) begin
            failures++;
            $display("FAIL evt_cnt_sat: got %0d expected %0d", cnt[0][1:0], e3);
        end
        step(4'b0000, mode, 4'b0001);
        checks++;
        if (cnt[0][1:0] !== 2'd0) begin
            failures++;
            $display("FAIL evt_cnt_clr: got %0d expected 0", cnt[0][1:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mode;
        mode = 8'b00_10_11_11;
        for (int n = 0; n < 10; n++) step(4'b0001, mode, 4'b0000);
        checks++;
        if (lvl[0][0] !== 1'b1 || lvl[1][0] !== 1'b1 || sts[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: lvl=%b%b sts=%b expected 111", lvl[0][0], lvl[1][0],
                     sts[0][0]);
        end
        #2;
        rst_b = 1'b0;
        model_reset();
        #1;
        for (int j = 0; j < 2; j++) begin
            checks++;
            if ({lvl[j], pls[j], sts[j], any[j], cnt[j]} !== 21'd0) begin
                failures++;
                $display("FAIL rst_mid_async dut%0d: got %h expected 0", j,
                         {lvl[j], pls[j], sts[j], any[j], cnt[j]});
            end
        end
        step(4'b0001, mode, 4'b0000);
        rst_b = 1'b1;
        for (int n = 0; n < 9; n++) begin
            step(4'b0001, mode, 4'b0000);
            checks++;
            if (pls[0][0] !== (n == 3) || pls[1][0] !== (n == 6)) begin
                failures++;
                $display("FAIL rst_mid_rise edge%0d: pulses %b%b expected %b%b", n,
                         pls[0][0], pls[1][0], n == 3, n == 6);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] in;
        logic [7:0] mode;
        logic [3:0] clr;
        in   = 4'b0001;
        mode = 8'b00_10_11_11;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) in = in ^ 4'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
            step(in, mode, clr);
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (lvl[j] !== exp_lvl(j)) begin
                    failures++;
                    $display("FAIL rnd_level dut%0d cyc%0d: got %b expected %b", j, n, lvl[j],
                             exp_lvl(j));
                end
                checks++;
                if (pls[j] !== exp_pls(j)) begin
                    failures++;
                    $display("FAIL rnd_pulse dut%0d cyc%0d: got %b expected %b", j, n, pls[j],
                             exp_pls(j));
                end
                checks++;
                if (sts[j] !== exp_sts(j) || any[j] !== (|exp_sts(j))) begin
                    failures++;
                    $display("FAIL rnd_sts dut%0d cyc%0d: got %b/%b expected %b/%b", j, n,
                             sts[j], any[j], exp_sts(j), |exp_sts(j));
                end
                checks++;
                if (cnt[j] !== exp_cnt(j)) begin
                    failures++;
                    $display("FAIL rnd_cnt dut%0d cyc%0d: got %h expected %h", j, n, cnt[j],
                             exp_cnt(j));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise_basic();
        test_filter();
        test_modes();
        test_clear_collision();
        test_evt_cnt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
